// File: rtl/led_sandbox_irq_pkg.sv
// Shared constants for the LED-sandbox interrupt controller: register offsets
// and the layout of the ACTIVE register.
package led_sandbox_irq_pkg;

   localparam int ID_W             = 4;
   localparam int ACTIVE_VALID_BIT = 15;

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_ENABLE  = 3'd1;
   localparam logic [2:0] ADDR_ACTIVE  = 3'd2;
   localparam logic [2:0] ADDR_FORCE   = 3'd3;
   localparam logic [2:0] ADDR_RAW     = 3'd4;

endpackage

// File: rtl/led_sandbox_irq_sync.sv
// Vector two-flop synchronizer followed by a history flop, giving a clean
// level (s2) and a one-cycle rising-edge pulse per line.
module led_sandbox_irq_sync
   import led_sandbox_irq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] irq_in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] s3_q, s3_d;

   always_comb begin
      s1_d = irq_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // s3 resets to 0 so a line already high at reset release still yields an edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/led_sandbox_irq_ctrl.sv
// Avalon-MM interrupt controller: latches edge events / follows level lines,
// masks with ENABLE and reports a registered irq_out plus lowest-index active ID.
module led_sandbox_irq_ctrl
   import led_sandbox_irq_pkg::*;
#(
   parameter int                 NUM_IRQ   = 8,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = NUM_IRQ'(1)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [2:0]         address,
   input  logic               chipselect,
   input  logic               write_n,
   input  logic               read_n,
   input  logic [15:0]        writedata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic [15:0]        readdata,
   output logic               irq_out
);

   localparam logic [NUM_IRQ-1:0] LEVEL_MASK = ~EDGE_MASK;

   logic [NUM_IRQ-1:0] sync_level;
   logic [NUM_IRQ-1:0] sync_rise;

   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] enable_q, enable_d;
   logic [15:0]        active_q, active_d;
   logic [15:0]        readdata_q, readdata_d;
   logic               irq_out_q, irq_out_d;

   logic               wr_en;
   logic [NUM_IRQ-1:0] wr_bits;
   logic [NUM_IRQ-1:0] masked;
   logic [ID_W-1:0]    active_id;
   logic               active_valid;
   logic               unused_inputs;

   led_sandbox_irq_sync #(
      .WIDTH (NUM_IRQ)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (irq_in),
      .level   (sync_level),
      .rise    (sync_rise)
   );

   assign wr_en         = chipselect & ~write_n;
   assign wr_bits       = writedata[NUM_IRQ-1:0];
   assign masked        = pending_q & enable_q;
   assign unused_inputs = ^{read_n, writedata[15:NUM_IRQ]};

   // Clears are applied before sets so a coincident hardware/forced set wins
   always_comb begin
      enable_d  = enable_q;
      pending_d = pending_q;
      if (wr_en && (address == ADDR_ENABLE)) begin
         enable_d = wr_bits;
      end
      if (wr_en && (address == ADDR_PENDING)) begin
         pending_d = pending_d & ~(wr_bits & EDGE_MASK);
      end
      if (wr_en && (address == ADDR_FORCE)) begin
         pending_d = pending_d | (wr_bits & EDGE_MASK);
      end
      pending_d = pending_d | (sync_rise & EDGE_MASK);
      pending_d = (pending_d & EDGE_MASK) | (sync_level & LEVEL_MASK);
   end

   always_comb begin
      active_valid = |masked;
      active_id    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (masked[i]) begin
            active_id = ID_W'(i);
         end
      end
      active_d                   = '0;
      active_d[ACTIVE_VALID_BIT] = active_valid;
      active_d[ID_W-1:0]         = active_id;
      irq_out_d                  = active_valid;
   end

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_PENDING: readdata_d[NUM_IRQ-1:0] = pending_q;
         ADDR_ENABLE:  readdata_d[NUM_IRQ-1:0] = enable_q;
         ADDR_ACTIVE:  readdata_d              = active_q;
         ADDR_RAW:     readdata_d[NUM_IRQ-1:0] = sync_level;
         default:      readdata_d              = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         enable_q   <= '0;
         active_q   <= '0;
         readdata_q <= '0;
         irq_out_q  <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         active_q   <= active_d;
         readdata_q <= readdata_d;
         irq_out_q  <= irq_out_d;
      end
   end

   assign readdata = readdata_q;
   assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_led_sandbox_irq_ctrl.sv
// Directed self-checking bench for led_sandbox_irq_ctrl with lines 0,5,7 edge
// and the rest level-sensitive.
module tb_led_sandbox_irq_ctrl;

   localparam logic [2:0] A_PENDING = 3'd0;
   localparam logic [2:0] A_ENABLE  = 3'd1;
   localparam logic [2:0] A_ACTIVE  = 3'd2;
   localparam logic [2:0] A_FORCE   = 3'd3;
   localparam logic [2:0] A_RAW     = 3'd4;
   localparam logic [2:0] A_RSVD    = 3'd6;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [15:0] writedata;
   logic [7:0]  irq_in;
   logic [15:0] readdata;
   logic        irq_out;

   int          totalCount;
   int          badCount;
   logic [15:0] rdValue;

   led_sandbox_irq_ctrl #(
      .NUM_IRQ   (8),
      .EDGE_MASK (8'hA1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .read_n     (read_n),
      .writedata  (writedata),
      .irq_in     (irq_in),
      .readdata   (readdata),
      .irq_out    (irq_out)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Single-cycle bus write, launched and retired on falling edges
   task automatic applyStimulus(input logic [2:0] addr, input logic [15:0] data);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      read_n     = 1'b1;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic readReg(input logic [2:0] addr, output logic [15:0] data);
      address    = addr;
      chipselect = 1'b1;
      read_n     = 1'b0;
      write_n    = 1'b1;
      @(negedge clk);
      data       = readdata;
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   // Directed scenarios, each timed in clocks from the stimulus edge
   initial begin
      totalCount = 0;
      badCount   = 0;
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      read_n     = 1'b1;
      writedata  = '0;
      irq_in     = '0;

      tick(2);
      checkOutput("reset_readdata", readdata, 16'h0000);
      checkOutput("reset_irq_out", {15'd0, irq_out}, 16'h0000);
      reset_n = 1'b1;
      tick(1);

      $display("[TB] edge line 0 pulse");
      applyStimulus(A_ENABLE, 16'h0001);
      address    = A_PENDING;
      chipselect = 1'b1;
      read_n     = 1'b0;
      irq_in[0]  = 1'b1;
      tick(1);
      irq_in[0]  = 1'b0;
      tick(2);
      checkOutput("pend_clk3_rd", readdata, 16'h0000);
      checkOutput("irq_clk3", {15'd0, irq_out}, 16'h0000);
      tick(1);
      checkOutput("pend_clk4_rd", readdata, 16'h0001);
      checkOutput("irq_clk4", {15'd0, irq_out}, 16'h0001);
      chipselect = 1'b0;
      read_n     = 1'b1;
      readReg(A_ACTIVE, rdValue);
      checkOutput("active_line0", rdValue, 16'h8000);

      $display("[TB] W1C and coincident set");
      applyStimulus(A_PENDING, 16'h0001);
      checkOutput("irq_w1c_hold", {15'd0, irq_out}, 16'h0001);
      tick(1);
      checkOutput("irq_w1c_drop", {15'd0, irq_out}, 16'h0000);
      readReg(A_ACTIVE, rdValue);
      checkOutput("active_cleared", rdValue, 16'h0000);
      irq_in[0] = 1'b1;
      tick(1);
      irq_in[0] = 1'b0;
      tick(1);
      applyStimulus(A_PENDING, 16'h0001);
      readReg(A_PENDING, rdValue);
      checkOutput("set_beats_w1c", rdValue, 16'h0001);
      applyStimulus(A_PENDING, 16'h0001);
      readReg(A_PENDING, rdValue);
      checkOutput("w1c_after", rdValue, 16'h0000);

      $display("[TB] level line 1");
      applyStimulus(A_ENABLE, 16'h0002);
      irq_in[1] = 1'b1;
      tick(3);
      checkOutput("lvl_irq_clk3", {15'd0, irq_out}, 16'h0000);
      tick(1);
      checkOutput("lvl_irq_clk4", {15'd0, irq_out}, 16'h0001);
      readReg(A_PENDING, rdValue);
      checkOutput("lvl_pending", rdValue, 16'h0002);
      readReg(A_RAW, rdValue);
      checkOutput("lvl_raw", rdValue, 16'h0002);
      applyStimulus(A_PENDING, 16'h0002);
      readReg(A_PENDING, rdValue);
      checkOutput("lvl_w1c_ignored", rdValue, 16'h0002);
      irq_in[1] = 1'b0;
      tick(3);
      checkOutput("lvl_drop_clk3", {15'd0, irq_out}, 16'h0001);
      tick(1);
      checkOutput("lvl_drop_clk4", {15'd0, irq_out}, 16'h0000);

      $display("[TB] priority via FORCE");
      applyStimulus(A_ENABLE, 16'h00FF);
      applyStimulus(A_FORCE, 16'h00A2);
      tick(1);
      readReg(A_ACTIVE, rdValue);
      checkOutput("active_5", rdValue, 16'h8005);
      readReg(A_PENDING, rdValue);
      checkOutput("force_edge_only", rdValue, 16'h00A0);
      readReg(A_FORCE, rdValue);
      checkOutput("force_reads_0", rdValue, 16'h0000);
      checkOutput("force_irq", {15'd0, irq_out}, 16'h0001);
      applyStimulus(A_PENDING, 16'h0020);
      tick(1);
      readReg(A_ACTIVE, rdValue);
      checkOutput("active_7", rdValue, 16'h8007);
      applyStimulus(A_PENDING, 16'h0080);
      tick(2);
      readReg(A_ACTIVE, rdValue);
      checkOutput("active_none", rdValue, 16'h0000);
      checkOutput("prio_irq_off", {15'd0, irq_out}, 16'h0000);

      $display("[TB] masking");
      applyStimulus(A_ENABLE, 16'h0000);
      irq_in[0] = 1'b1;
      tick(1);
      irq_in[0] = 1'b0;
      tick(3);
      readReg(A_PENDING, rdValue);
      checkOutput("mask_pending", rdValue, 16'h0001);
      checkOutput("mask_irq_off", {15'd0, irq_out}, 16'h0000);
      applyStimulus(A_ENABLE, 16'h0001);
      checkOutput("unmask_clk0", {15'd0, irq_out}, 16'h0000);
      tick(1);
      checkOutput("unmask_clk1", {15'd0, irq_out}, 16'h0001);

      $display("[TB] async reset mid-operation");
      applyStimulus(A_ENABLE, 16'h00FF);
      irq_in = 8'h5E;
      applyStimulus(A_FORCE, 16'h00A0);
      tick(4);
      readReg(A_PENDING, rdValue);
      checkOutput("all_pending", rdValue, 16'h00FF);
      checkOutput("all_irq", {15'd0, irq_out}, 16'h0001);
      #2;
      reset_n = 1'b0;
      irq_in  = 8'h5F;
      #1;
      checkOutput("async_rd", readdata, 16'h0000);
      checkOutput("async_irq", {15'd0, irq_out}, 16'h0000);
      tick(1);
      reset_n    = 1'b1;
      address    = A_PENDING;
      chipselect = 1'b1;
      read_n     = 1'b0;
      tick(3);
      checkOutput("post_rst_clk3", readdata, 16'h0000);
      tick(1);
      checkOutput("post_rst_clk4", readdata, 16'h005F);
      chipselect = 1'b0;
      read_n     = 1'b1;
      readReg(A_RAW, rdValue);
      checkOutput("post_rst_raw", rdValue, 16'h005F);
      readReg(A_ENABLE, rdValue);
      checkOutput("post_rst_enable", rdValue, 16'h0000);

      $display("[TB] reserved and unused bits");
      readReg(A_RSVD, rdValue);
      checkOutput("rsvd_read", rdValue, 16'h0000);
      applyStimulus(A_ENABLE, 16'hFFFF);
      readReg(A_ENABLE, rdValue);
      checkOutput("enable_width", rdValue, 16'h00FF);
      applyStimulus(A_RSVD, 16'h0000);
      readReg(A_ENABLE, rdValue);
      checkOutput("rsvd_write_ignored", rdValue, 16'h00FF);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
